// File: rtl/uart_seq_pkg.sv
// Shared encodings for the UART channel sequencer: instruction codes, FSM states, channel ids.
package uart_seq_pkg;

    localparam logic [2:0] UART_NOP   = 3'b000;
    localparam logic [2:0] UART_TELL  = 3'b001;
    localparam logic [2:0] UART_READ  = 3'b010;
    localparam logic [2:0] UART_WRITE = 3'b011;

    localparam logic UART_CH_A = 1'b0;
    localparam logic UART_CH_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_RX = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/uart_seq_timer.sv
// Load/count/expire cycle counter bounding how long one command may wait on the UART cores.
module uart_seq_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current cycle is the LIMIT-th one spent waiting.
    assign expired_o = en_i && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/uart_channel_sequencer.sv
// Runs one decoded UART instruction on channel A or B and returns a single response.
// Optional per-command timeout is compiled in with UART_SEQ_TIMEOUT_EN.
module uart_channel_sequencer
    import uart_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_channel,
    input  logic [2:0]  cmd_instr,
    input  logic [7:0]  cmd_code,
    input  logic [7:0]  cmd_wdata,
    output logic [1:0]  tx_valid,
    output logic [15:0] tx_data,
    input  logic [1:0]  tx_ready,
    input  logic [1:0]  rx_valid,
    input  logic [15:0] rx_data,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        busy
);

    seq_state_e state_q, state_d;
    logic       ch_q, ch_d;
    logic       is_read_q, is_read_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;
    logic       timer_load;
    logic       timeout_hit;
    logic       tx_hit, rx_hit;
    logic [7:0] rx_byte;

    assign tx_hit  = tx_ready[ch_q];
    assign rx_hit  = rx_valid[ch_q];
    assign rx_byte = (ch_q == UART_CH_B) ? rx_data[15:8] : rx_data[7:0];

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        is_read_d  = is_read_q;
        byte_d     = byte_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    ch_d      = cmd_channel;
                    is_read_d = (cmd_instr == UART_READ);
                    byte_d    = (cmd_instr == UART_WRITE) ? cmd_wdata : cmd_code;
                    case (cmd_instr)
                        UART_TELL, UART_READ, UART_WRITE: begin
                            state_d    = ST_SEND;
                            timer_load = 1'b1;
                        end
                        default: begin
                            state_d    = ST_DONE;
                            rsp_data_d = 8'h00;
                            rsp_err_d  = 1'b0;
                        end
                    endcase
                end
            end
            ST_SEND: begin
                // A handshake in the expiry cycle still counts as success.
                if (tx_hit) begin
                    if (is_read_q) begin
                        state_d = ST_WAIT_RX;
                    end else begin
                        state_d    = ST_DONE;
                        rsp_data_d = 8'h00;
                        rsp_err_d  = 1'b0;
                    end
                end else if (timeout_hit) begin
                    state_d    = ST_DONE;
                    rsp_data_d = 8'h00;
                    rsp_err_d  = 1'b1;
                end
            end
            ST_WAIT_RX: begin
                if (rx_hit) begin
                    state_d    = ST_DONE;
                    rsp_data_d = rx_byte;
                    rsp_err_d  = 1'b0;
                end else if (timeout_hit) begin
                    state_d    = ST_DONE;
                    rsp_data_d = 8'h00;
                    rsp_err_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= UART_CH_A;
            is_read_q  <= 1'b0;
            byte_q     <= 8'h00;
            rsp_data_q <= 8'h00;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            is_read_q  <= is_read_d;
            byte_q     <= byte_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef UART_SEQ_TIMEOUT_EN
    logic timer_en;
    assign timer_en = (state_q == ST_SEND) || (state_q == ST_WAIT_RX);

    uart_seq_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (timer_load),
        .en_i     (timer_en),
        .expired_o(timeout_hit)
    );

    assign rsp_err = rsp_err_q;
`else
    logic unused_timeout_cfg;
    assign timeout_hit        = 1'b0;
    assign rsp_err            = 1'b0;
    assign unused_timeout_cfg = rsp_err_q | timer_load | (TIMEOUT_CYCLES == 0);
`endif

    // Only the selected channel carries the byte; the other lane stays zero.
    always_comb begin
        tx_valid = 2'b00;
        tx_data  = 16'h0000;
        if (state_q == ST_SEND) begin
            if (ch_q == UART_CH_B) begin
                tx_valid = 2'b10;
                tx_data  = {byte_q, 8'h00};
            end else begin
                tx_valid = 2'b01;
                tx_data  = {8'h00, byte_q};
            end
        end
    end

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_channel_sequencer.sv
// Directed bench for uart_channel_sequencer; timeout scenario runs when UART_SEQ_TIMEOUT_EN is defined.
module tb_uart_channel_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_channel;
    logic [2:0]  cmd_instr;
    logic [7:0]  cmd_code;
    logic [7:0]  cmd_wdata;
    logic [1:0]  tx_valid;
    logic [15:0] tx_data;
    logic [1:0]  tx_ready;
    logic [1:0]  rx_valid;
    logic [15:0] rx_data;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    uart_channel_sequencer #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_channel(cmd_channel),
        .cmd_instr  (cmd_instr),
        .cmd_code   (cmd_code),
        .cmd_wdata  (cmd_wdata),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic offer(input logic ch, input logic [2:0] instr, input logic [7:0] code,
                         input logic [7:0] wdata);
        cmd_valid   = 1'b1;
        cmd_channel = ch;
        cmd_instr   = instr;
        cmd_code    = code;
        cmd_wdata   = wdata;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready_low: got %b exp 0", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_valid !== 2'b00) begin errors++; $display("FAIL rst_tx_valid: got %b exp 00", tx_valid); end
        checks++; if (tx_data !== 16'h0000) begin errors++; $display("FAIL rst_tx_data: got %h exp 0000", tx_data); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL rst_rsp_data: got %h exp 00", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b exp 0", rsp_err); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready_high: got %b exp 1", cmd_ready); end
    endtask

    task automatic test_tell();
        offer(1'b0, 3'b001, 8'h5A, 8'hA5);
        tx_ready = 2'b01;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL tell_accept: got %b exp 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (tx_valid !== 2'b01) begin errors++; $display("FAIL tell_tx_valid: got %b exp 01", tx_valid); end
        checks++; if (tx_data !== 16'h005A) begin errors++; $display("FAIL tell_tx_data: got %h exp 005a", tx_data); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tell_rsp_early: got %b exp 0", rsp_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL tell_rsp_valid: got %b exp 1", rsp_valid); end
        checks++; if (tx_valid !== 2'b00) begin errors++; $display("FAIL tell_tx_drop: got %b exp 00", tx_valid); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL tell_rsp_data: got %h exp 00", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL tell_rsp_err: got %b exp 0", rsp_err); end
        @(negedge clk);
        tx_ready = 2'b00;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL tell_rsp_one_cycle: got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tell_idle: got %b exp 0", busy); end
    endtask

    task automatic test_write_stall();
        // Channel A ready during the stall must not complete a channel B transfer.
        offer(1'b1, 3'b011, 8'h11, 8'hC3);
        tx_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            checks++; if (tx_valid !== 2'b10) begin errors++; $display("FAIL write_tx_valid[%0d]: got %b exp 10", i, tx_valid); end
            checks++; if (tx_data !== 16'hC300) begin errors++; $display("FAIL write_tx_data[%0d]: got %h exp c300", i, tx_data); end
            checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL write_wait[%0d]: got busy=%b rsp=%b exp busy=1 rsp=0", i, busy, rsp_valid); end
            if (i == 4) tx_ready = 2'b10;
        end
        @(negedge clk);
        tx_ready = 2'b00;
        checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL write_rsp: got rsp=%b busy=%b exp 1 1", rsp_valid, busy); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL write_rsp_data: got %h exp 00", rsp_data); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_idle: got %b exp 0", busy); end
    endtask

    task automatic test_read();
        offer(1'b0, 3'b010, 8'h10, 8'hFF);
        tx_ready = 2'b01;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (tx_data !== 16'h0010) begin errors++; $display("FAIL read_tx_data: got %h exp 0010", tx_data); end
        // Strobe coincident with the TX handshake must be dropped.
        rx_valid = 2'b01;
        rx_data  = 16'h00AA;
        @(negedge clk);
        tx_ready = 2'b00;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL read_handshake_rx: got rsp=%b busy=%b exp 0 1", rsp_valid, busy); end
        checks++; if (tx_valid !== 2'b00) begin errors++; $display("FAIL read_tx_drop: got %b exp 00", tx_valid); end
        rx_valid = 2'b10;
        rx_data  = 16'hEE00;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_other_channel: got %b exp 0", rsp_valid); end
        rx_valid = 2'b01;
        rx_data  = 16'h007F;
        @(negedge clk);
        rx_valid = 2'b00;
        rx_data  = 16'h0000;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL read_rsp_valid: got %b exp 1", rsp_valid); end
        checks++; if (rsp_data !== 8'h7F) begin errors++; $display("FAIL read_rsp_data: got %h exp 7f", rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL read_rsp_err: got %b exp 0", rsp_err); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h7F) begin errors++; $display("FAIL read_hold: got rsp=%b data=%h exp 0 7f", rsp_valid, rsp_data); end
    endtask

    task automatic test_nop();
        offer(1'b0, 3'b000, 8'h77, 8'h66);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL nop_accept: got %b exp 1", cmd_ready); end
        @(negedge clk);
        cmd_instr   = 3'b110;
        cmd_channel = 1'b1;
        checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL nop_done: got ready=%b rsp=%b exp 0 1", cmd_ready, rsp_valid); end
        checks++; if (tx_valid !== 2'b00) begin errors++; $display("FAIL nop_tx: got %b exp 00", tx_valid); end
        checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL nop_rsp_data: got %h exp 00", rsp_data); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL nop_reaccept: got ready=%b rsp=%b exp 1 0", cmd_ready, rsp_valid); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL instr110_done: got ready=%b rsp=%b exp 0 1", cmd_ready, rsp_valid); end
        checks++; if (tx_valid !== 2'b00) begin errors++; $display("FAIL instr110_tx: got %b exp 00", tx_valid); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL instr110_idle: got ready=%b rsp=%b exp 1 0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_back_to_back();
        offer(1'b1, 3'b001, 8'h3C, 8'h00);
        tx_ready = 2'b11;
        @(negedge clk);
        offer(1'b0, 3'b011, 8'h00, 8'h81);
        checks++; if (tx_valid !== 2'b10 || tx_data !== 16'h3C00) begin errors++; $display("FAIL b2b_tx1: got %b %h exp 10 3c00", tx_valid, tx_data); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_done1: got rsp=%b ready=%b exp 1 0", rsp_valid, cmd_ready); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_ready: got ready=%b rsp=%b exp 1 0", cmd_ready, rsp_valid); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (tx_valid !== 2'b01 || tx_data !== 16'h0081) begin errors++; $display("FAIL b2b_tx2: got %b %h exp 01 0081", tx_valid, tx_data); end
        @(negedge clk);
        tx_ready = 2'b00;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b exp 1", rsp_valid); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b exp 0", busy); end
    endtask

`ifdef UART_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        offer(1'b0, 3'b010, 8'h20, 8'h00);
        tx_ready = 2'b01;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (k == 2) tx_ready = 2'b00;
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL timeout_wait[%0d]: got rsp=%b busy=%b exp 0 1", k, rsp_valid, busy); end
        end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL timeout_rsp_valid: got %b exp 1", rsp_valid); end
        checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL timeout_rsp_err: got %b exp 1", rsp_err); end
        checks++; if (rsp_data !== 8'h00 || tx_valid !== 2'b00) begin errors++; $display("FAIL timeout_data_tx: got %h %b exp 00 00", rsp_data, tx_valid); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b1) begin errors++; $display("FAIL timeout_hold: got rsp=%b err=%b exp 0 1", rsp_valid, rsp_err); end
    endtask
`endif

    task automatic test_slow_read();
        offer(1'b1, 3'b010, 8'h42, 8'h00);
        tx_ready = 2'b10;
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (tx_valid !== 2'b10 || tx_data !== 16'h4200) begin errors++; $display("FAIL slow_tx: got %b %h exp 10 4200", tx_valid, tx_data); end
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            tx_ready = 2'b00;
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL slow_wait[%0d]: got rsp=%b busy=%b exp 0 1", k, rsp_valid, busy); end
        end
        @(negedge clk);
        rx_valid = 2'b11;
        rx_data  = 16'h9911;
        @(negedge clk);
        rx_valid = 2'b00;
        rx_data  = 16'h0000;
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h99) begin errors++; $display("FAIL slow_rsp: got rsp=%b data=%h exp 1 99", rsp_valid, rsp_data); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL slow_rsp_err: got %b exp 0", rsp_err); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        offer(1'b0, 3'b010, 8'h55, 8'h00);
        tx_ready = 2'b01;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        tx_ready = 2'b00;
        checks++; if (busy !== 1'b1 || tx_valid !== 2'b00) begin errors++; $display("FAIL rmid_wait_rx: got busy=%b tx=%b exp 1 00", busy, tx_valid); end
        rst      = 1'b1;
        rx_valid = 2'b01;
        rx_data  = 16'h0066;
        @(negedge clk);
        rx_valid = 2'b00;
        rx_data  = 16'h0000;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle: got busy=%b rsp=%b exp 0 0", busy, rsp_valid); end
        checks++; if (tx_valid !== 2'b00 || tx_data !== 16'h0000) begin errors++; $display("FAIL rmid_tx: got %b %h exp 00 0000", tx_valid, tx_data); end
        checks++; if (rsp_data !== 8'h00 || rsp_err !== 1'b0) begin errors++; $display("FAIL rmid_rsp_regs: got %h %b exp 00 0", rsp_data, rsp_err); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst: got %b exp 0", cmd_ready); end
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got %b exp 1", cmd_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp[%0d]: got rsp=%b busy=%b exp 0 0", k, rsp_valid, busy); end
        end
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_channel = 1'b0;
        cmd_instr   = 3'b000;
        cmd_code    = 8'h00;
        cmd_wdata   = 8'h00;
        tx_ready    = 2'b00;
        rx_valid    = 2'b00;
        rx_data     = 16'h0000;

        test_reset();
        test_tell();
        test_write_stall();
        test_read();
        test_nop();
        test_back_to_back();
`ifdef UART_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_slow_read();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
